// File: rtl/complex_instr_sequencer.sv
// Cracks RISC-V AMO instructions into a load / ALU / store micro-op sequence.
// Every other instruction is rejected with a one-cycle o_bad pulse.
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

`ifndef COMPLEX_INSTR_SEQUENCER_TYPES
`define COMPLEX_INSTR_SEQUENCER_TYPES
typedef enum logic [1:0] {
  UNIT_NONE = 2'd0,
  UNIT_ALU  = 2'd1,
  UNIT_MEM  = 2'd2
} unit_e;

typedef enum logic [3:0] {
  OP_NONE          = 4'd0,
  OP_ADD           = 4'd1,
  OP_XOR           = 4'd2,
  OP_AND           = 4'd3,
  OP_OR            = 4'd4,
  OP_MIN           = 4'd5,
  OP_MAX           = 4'd6,
  OP_MEM_LOAD_AMO  = 4'd7,
  OP_MEM_STORE_AMO = 4'd8
} op_e;

typedef struct packed {
  unit_e      unit;
  op_e        op;
  logic       has_rd;
  logic [4:0] rd;
  logic       has_rs1;
  logic       use_rs1;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       alt_rd;
  logic       alt_rs2;
  logic [1:0] op_size;
  logic [1:0] attri;
} decoded_instr_t;
`endif

module complex_instr_sequencer #(
  parameter int unsigned INSTR_WIDTH   = `INSTR_WIDTH,
  parameter bit          SWAP_SKIP_ALU = 1'b1,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_valid,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output logic                   o_ready,
  output logic                   o_uop_valid,
  input  logic                   i_uop_ready,
  output decoded_instr_t         o_uop,
  output logic [1:0]             o_step,
  output logic                   o_last,
  output logic                   o_bad,
  output logic [CNT_WIDTH-1:0]   o_cracked_cnt
);

  localparam logic [6:0] OpcAmo = 7'b0101111;
  localparam logic [4:0] F5Swap = 5'b00001;
  localparam logic [4:0] F5Add  = 5'b00000;
  localparam logic [4:0] F5Xor  = 5'b00100;
  localparam logic [4:0] F5And  = 5'b01100;
  localparam logic [4:0] F5Or   = 5'b01000;
  localparam logic [4:0] F5Min  = 5'b10000;
  localparam logic [4:0] F5Max  = 5'b10100;
  localparam logic [4:0] F5Minu = 5'b11000;
  localparam logic [4:0] F5Maxu = 5'b11100;

  typedef enum logic [1:0] {StIdle, StEmit, StBad} state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [1:0]             step_q, step_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic       in_supported;
  logic [4:0] rd, rs1, rs2, funct5;
  logic       size_dw, aq, rl, is_swap, is_unsigned, last;
  logic [1:0] mem_size, mem_attri;
  op_e        alu_op;

  always_comb begin
    in_supported = (i_instr[6:0] == OpcAmo) &&
                   (i_instr[14:12] inside {3'b010, 3'b011}) &&
                   (i_instr[31:27] inside {F5Swap, F5Add, F5Xor, F5And, F5Or,
                                           F5Min, F5Max, F5Minu, F5Maxu});
  end

  // Fields of the held instruction; only meaningful while emitting.
  assign rd          = instr_q[11:7];
  assign size_dw     = instr_q[12];
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];
  assign rl          = instr_q[25];
  assign aq          = instr_q[26];
  assign funct5      = instr_q[31:27];
  assign is_swap     = (funct5 == F5Swap);
  assign is_unsigned = (funct5 == F5Minu) || (funct5 == F5Maxu);
  assign last        = (step_q == 2'd2);
  assign mem_size    = size_dw ? 2'b11 : 2'b10;
  assign mem_attri   = {aq, rl | is_unsigned};

  always_comb begin
    case (funct5)
      F5Swap, F5Add:  alu_op = OP_ADD;
      F5Xor:          alu_op = OP_XOR;
      F5And:          alu_op = OP_AND;
      F5Or:           alu_op = OP_OR;
      F5Min, F5Minu:  alu_op = OP_MIN;
      F5Max, F5Maxu:  alu_op = OP_MAX;
      default:        alu_op = OP_NONE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      instr_q <= '0;
      step_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush overrides every other event, including acceptance in IDLE.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = StIdle;
      step_d  = 2'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_valid) begin
            instr_d = i_instr;
            step_d  = 2'd0;
            state_d = in_supported ? StEmit : StBad;
          end
        end
        StEmit: begin
          if (i_uop_ready) begin
            if (last) begin
              state_d = StIdle;
              step_d  = 2'd0;
              cnt_d   = cnt_q + CNT_WIDTH'(1);
            end else if (step_q == 2'd0 && !(SWAP_SKIP_ALU && is_swap)) begin
              step_d = 2'd1;
            end else begin
              step_d = 2'd2;
            end
          end
        end
        StBad:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    o_ready       = (state_q == StIdle);
    o_uop_valid   = (state_q == StEmit);
    o_bad         = (state_q == StBad);
    o_cracked_cnt = cnt_q;
    o_step        = 2'd0;
    o_last        = 1'b0;
    o_uop         = '0;
    if (state_q == StEmit) begin
      o_step = step_q;
      o_last = last;
      case (step_q)
        2'd0: begin
          o_uop.unit    = UNIT_MEM;
          o_uop.op      = OP_MEM_LOAD_AMO;
          o_uop.has_rd  = 1'b1;
          o_uop.rd      = rd;
          o_uop.has_rs1 = 1'b1;
          o_uop.rs1     = rs1;
          o_uop.op_size = mem_size;
          o_uop.attri   = mem_attri;
        end
        2'd1: begin
          o_uop.unit    = UNIT_ALU;
          o_uop.op      = alu_op;
          o_uop.alt_rd  = 1'b1;
          o_uop.has_rs1 = 1'b1;
          o_uop.rs1     = rd;
          o_uop.rs2     = is_swap ? 5'd0 : rs2;
          o_uop.op_size = {1'b0, ~size_dw};
          o_uop.attri   = {1'b0, is_unsigned};
        end
        default: begin
          o_uop.unit    = UNIT_MEM;
          o_uop.op      = OP_MEM_STORE_AMO;
          o_uop.use_rs1 = 1'b1;
          o_uop.alt_rs2 = 1'b1;
          o_uop.rs1     = rs1;
          o_uop.op_size = mem_size;
          o_uop.attri   = mem_attri;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_instr_sequencer.sv
// Bench for complex_instr_sequencer: two instances (SWAP skip on / off, 16-bit / 2-bit counter)
// driven with directed and random instructions, checked against a field-level reference model.
module tb_complex_instr_sequencer;

  logic clk, rst_n;
  logic flush[2], valid[2], uop_ready[2];
  logic [31:0] instr[2];

  logic ready0, ready1, uvalid0, uvalid1, last0, last1, bad0, bad1;
  logic [1:0] step0, step1;
  decoded_instr_t uop0, uop1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int npass = 0;
  int ntot  = 0;
  int unsigned exp_cnt[2];
  logic [4:0] f5tab[9];

  complex_instr_sequencer #(.INSTR_WIDTH(32), .SWAP_SKIP_ALU(1'b1), .CNT_WIDTH(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush[0]), .i_valid(valid[0]), .i_instr(instr[0]),
    .o_ready(ready0), .o_uop_valid(uvalid0), .i_uop_ready(uop_ready[0]), .o_uop(uop0),
    .o_step(step0), .o_last(last0), .o_bad(bad0), .o_cracked_cnt(cnt0)
  );

  complex_instr_sequencer #(.INSTR_WIDTH(32), .SWAP_SKIP_ALU(1'b0), .CNT_WIDTH(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush[1]), .i_valid(valid[1]), .i_instr(instr[1]),
    .o_ready(ready1), .o_uop_valid(uvalid1), .i_uop_ready(uop_ready[1]), .o_uop(uop1),
    .o_step(step1), .o_last(last1), .o_bad(bad1), .o_cracked_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic g_ready(input int d);   return d != 0 ? ready1 : ready0;   endfunction
  function automatic logic g_uvalid(input int d);  return d != 0 ? uvalid1 : uvalid0; endfunction
  function automatic logic g_last(input int d);    return d != 0 ? last1 : last0;     endfunction
  function automatic logic g_bad(input int d);     return d != 0 ? bad1 : bad0;       endfunction
  function automatic logic [1:0] g_step(input int d); return d != 0 ? step1 : step0;  endfunction
  function automatic decoded_instr_t g_uop(input int d); return d != 0 ? uop1 : uop0; endfunction
  function automatic logic [15:0] g_cnt(input int d);
    return d != 0 ? {14'd0, cnt1} : cnt0;
  endfunction
  function automatic int unsigned cnt_mod(input int d); return d != 0 ? 4 : 65536; endfunction
  function automatic bit skip_alu(input int d);         return d == 0;             endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: classification and micro-op contents from the AMO encoding.
  function automatic bit is_supported(input logic [31:0] w);
    bit f5ok = 1'b0;
    for (int i = 0; i < 9; i++) if (w[31:27] == f5tab[i]) f5ok = 1'b1;
    return (w[6:0] == 7'b0101111) && (w[14:12] == 3'd2 || w[14:12] == 3'd3) && f5ok;
  endfunction

  function automatic decoded_instr_t exp_uop(input logic [31:0] w, input int s);
    decoded_instr_t u = '0;
    logic [4:0] f5 = w[31:27];
    logic uns = (f5 == 5'b11000) || (f5 == 5'b11100);
    logic [1:0] msize = w[12] ? 2'b11 : 2'b10;
    logic [1:0] mattr = {w[26], w[25] | uns};
    if (s == 0) begin
      u.unit = UNIT_MEM; u.op = OP_MEM_LOAD_AMO; u.has_rd = 1'b1; u.rd = w[11:7];
      u.has_rs1 = 1'b1; u.rs1 = w[19:15]; u.op_size = msize; u.attri = mattr;
    end else if (s == 1) begin
      u.unit = UNIT_ALU; u.alt_rd = 1'b1; u.has_rs1 = 1'b1; u.rs1 = w[11:7];
      u.rs2 = (f5 == 5'b00001) ? 5'd0 : w[24:20];
      u.op_size = {1'b0, ~w[12]}; u.attri = {1'b0, uns};
      case (f5)
        5'b00001, 5'b00000: u.op = OP_ADD;
        5'b00100:           u.op = OP_XOR;
        5'b01100:           u.op = OP_AND;
        5'b01000:           u.op = OP_OR;
        5'b10000, 5'b11000: u.op = OP_MIN;
        default:            u.op = OP_MAX;
      endcase
    end else begin
      u.unit = UNIT_MEM; u.op = OP_MEM_STORE_AMO; u.use_rs1 = 1'b1; u.alt_rs2 = 1'b1;
      u.rs1 = w[19:15]; u.op_size = msize; u.attri = mattr;
    end
    return u;
  endfunction

  task automatic chk_reset(input int d);
    chk("rst_ready", g_ready(d), 1);
    chk("rst_uop_valid", g_uvalid(d), 0);
    chk("rst_uop", g_uop(d), 0);
    chk("rst_step", g_step(d), 0);
    chk("rst_last", g_last(d), 0);
    chk("rst_bad", g_bad(d), 0);
    chk("rst_cnt", g_cnt(d), 0);
  endtask

  // Offers one instruction and walks its whole sequence, stalling stall_n cycles at stall_step.
  task automatic run_instr(input int d, input logic [31:0] w, input int stall_step,
                           input int stall_n);
    int seq[$];
    decoded_instr_t e;
    chk("idle_ready", g_ready(d), 1);
    valid[d] = 1'b1;
    instr[d] = w;
    tick();
    valid[d] = 1'b0;
    instr[d] = $urandom;
    if (!is_supported(w)) begin
      chk("bad_pulse", g_bad(d), 1);
      chk("bad_no_uop", g_uvalid(d), 0);
      chk("bad_uop_zero", g_uop(d), 0);
      chk("bad_not_ready", g_ready(d), 0);
      tick();
      chk("bad_one_cycle", g_bad(d), 0);
      chk("bad_ready_again", g_ready(d), 1);
      chk("bad_still_no_uop", g_uvalid(d), 0);
      return;
    end
    if (w[31:27] == 5'b00001 && skip_alu(d)) seq = '{0, 2};
    else seq = '{0, 1, 2};
    foreach (seq[i]) begin
      e = exp_uop(w, seq[i]);
      uop_ready[d] = 1'b0;
      if (seq[i] == stall_step) begin
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_valid", g_uvalid(d), 1);
          chk("stall_uop", g_uop(d), e);
          chk("stall_step", g_step(d), seq[i]);
          chk("stall_not_ready", g_ready(d), 0);
          tick();
        end
      end
      uop_ready[d] = 1'b1;
      chk("uop_valid", g_uvalid(d), 1);
      chk("uop_step", g_step(d), seq[i]);
      chk("uop_last", g_last(d), seq[i] == 2);
      chk("uop_fields", g_uop(d), e);
      chk("busy_not_ready", g_ready(d), 0);
      tick();
    end
    uop_ready[d] = 1'b0;
    exp_cnt[d] = (exp_cnt[d] + 1) % cnt_mod(d);
    chk("done_no_uop", g_uvalid(d), 0);
    chk("done_ready", g_ready(d), 1);
    chk("done_cnt", g_cnt(d), exp_cnt[d]);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] amoadd_w = 32'h0020A1AF;
    logic [31:0] amoswap_d = {5'b00001, 1'b1, 1'b0, 5'd7, 5'd5, 3'b011, 5'd9, 7'b0101111};
    logic [31:0] addi = 32'h00500093;
    logic [31:0] lr_w = {5'b00010, 2'b00, 5'd0, 5'd1, 3'b010, 5'd2, 7'b0101111};
    f5tab = '{5'b00001, 5'b00000, 5'b00100, 5'b01100, 5'b01000,
              5'b10000, 5'b10100, 5'b11000, 5'b11100};
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; valid[d] = 1'b0; uop_ready[d] = 1'b0; instr[d] = '0; exp_cnt[d] = 0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_reset(0);
    chk_reset(1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_reset(0);

    // AMOADD.W straight through, then with a 5-cycle stall at step 1
    run_instr(0, amoadd_w, 3, 0);
    chk("amoadd_cnt_one", g_cnt(0), 1);
    run_instr(0, amoadd_w, 1, 5);

    // AMOSWAP.D: two micro-ops with skip, three without
    run_instr(0, amoswap_d, 3, 0);
    run_instr(1, amoswap_d, 1, 2);

    // Rejected instructions
    run_instr(0, addi, 3, 0);
    run_instr(1, lr_w, 3, 0);

    // Flush at step 1 with a valid instruction offered
    valid[0] = 1'b1; instr[0] = amoadd_w;
    tick();
    valid[0] = 1'b0; uop_ready[0] = 1'b1;
    tick();
    uop_ready[0] = 1'b0;
    chk("pre_flush_step", g_step(0), 1);
    flush[0] = 1'b1; valid[0] = 1'b1;
    tick();
    chk("flush_no_uop", g_uvalid(0), 0);
    chk("flush_cnt", g_cnt(0), exp_cnt[0]);
    chk("flush_idle", g_ready(0), 1);
    // Flush while idle must block acceptance
    tick();
    flush[0] = 1'b0; valid[0] = 1'b0;
    chk("flush_idle_no_accept", g_uvalid(0), 0);
    chk("flush_idle_no_bad", g_bad(0), 0);
    chk("flush_idle_ready", g_ready(0), 1);

    // Asynchronous reset in the middle of a sequence
    valid[0] = 1'b1; instr[0] = amoadd_w;
    tick();
    valid[0] = 1'b0; uop_ready[0] = 1'b1;
    tick();
    uop_ready[0] = 1'b0;
    chk("pre_rst_valid", g_uvalid(0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_discarded", g_uvalid(0), 0);
    chk("post_rst_ready", g_ready(0), 1);

    // Two-bit counter wraps after four sequences
    for (int i = 0; i < 4; i++) run_instr(1, amoadd_w, 3, 0);
    chk("cnt_wrap", g_cnt(1), 0);

    // Random instructions on either instance
    for (int it = 0; it < 60; it++) begin
      int d = int'($urandom_range(0, 1));
      w = $urandom;
      case ($urandom_range(0, 3))
        0, 1: begin
          w[6:0] = 7'b0101111;
          w[14:12] = {2'b01, 1'($urandom_range(0, 1))};
          w[31:27] = f5tab[$urandom_range(0, 8)];
        end
        2: w[6:0] = 7'b0101111;
        default: ;
      endcase
      run_instr(d, w, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
